// File: rtl/demap_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : demap_arbiter
// Description : Packet-level round-robin arbiter that shares one QPSK
//               demapper between up to 4 IQ sources. The arbiter locks onto
//               one source for a whole tlast-delimited packet, forwards its
//               beats (registered) to the demapper, and tags each beat with
//               the source index on tuser. The demapper side has no tready,
//               so the output is valid-only.
//
// Parameters  : IQ_DW        width of one I or Q component (beat = {Q,I})
//               NUM_SRC      number of requesters, 1..4
//               TIMEOUT_CYC  stall limit in cycles (watchdog build only)
//
// Ports       : clk_i              clock
//               reset_ni           asynchronous active-low reset
//               s_axis_in_tdata    per-source beats, source k at [k*2*IQ_DW +: 2*IQ_DW]
//               s_axis_in_tlast    per-source end of packet
//               s_axis_in_tvalid   per-source beat valid
//               s_axis_in_tready   per-source ready, at most one bit set
//               m_axis_out_tdata   beat to the demapper
//               m_axis_out_tuser   index of the source that produced the beat
//               m_axis_out_tlast   end of packet
//               m_axis_out_tvalid  beat valid (no backpressure)
//               grant_o            index of the currently locked source
//               busy_o             1 while a source is locked
//               err_o              one-cycle pulse on watchdog abort
//
// Options     : `define DEMAP_ARB_TIMEOUT_EN to enable the stall watchdog.
//               Without it a locked source keeps the grant until its tlast
//               and err_o is tied to 0.
//
// Revision    : 1.0  initial release
// ============================================================================
module demap_arbiter #(
    parameter int IQ_DW       = 16,
    parameter int NUM_SRC     = 2,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    input  logic [NUM_SRC*IQ_DW*2-1:0]   s_axis_in_tdata,
    input  logic [NUM_SRC-1:0]           s_axis_in_tlast,
    input  logic [NUM_SRC-1:0]           s_axis_in_tvalid,
    output logic [NUM_SRC-1:0]           s_axis_in_tready,
    output logic [IQ_DW*2-1:0]           m_axis_out_tdata,
    output logic [1:0]                   m_axis_out_tuser,
    output logic                         m_axis_out_tlast,
    output logic                         m_axis_out_tvalid,
    output logic [1:0]                   grant_o,
    output logic                         busy_o,
    output logic                         err_o
);

    localparam int         c_BEAT_W   = IQ_DW * 2;
    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_GRANT = 1'b1;
    localparam logic [1:0] c_LAST_SRC = 2'(NUM_SRC - 1);
    localparam logic [2:0] c_NUM_SRC3 = 3'(NUM_SRC);

    // Elaboration-time guard against configurations the 2-bit index cannot hold.
    generate
        if (NUM_SRC < 1 || NUM_SRC > 4 || TIMEOUT_CYC < 1) begin : g_param_check
            $error("demap_arbiter: NUM_SRC must be 1..4 and TIMEOUT_CYC >= 1");
        end
    endgenerate

    logic [0:0]          r_state;
    logic [1:0]          r_grant;
    logic [1:0]          r_rr;
    logic [c_BEAT_W-1:0] r_out_data;
    logic [1:0]          r_out_user;
    logic                r_out_last;
    logic                r_out_valid;

    logic [NUM_SRC-1:0]  w_req_rot;
    logic                w_any_req;
    logic [1:0]          w_offset;
    logic [2:0]          w_sum;
    logic [1:0]          w_winner;
    logic [NUM_SRC-1:0]  w_ready;
    logic [c_BEAT_W-1:0] w_sel_data;
    logic                w_sel_last;
    logic                w_accept;
    logic [1:0]          w_rr_next;

    // ------------------------------------------------------------------------
    // Round-robin search: rotate the request vector so bit j is the source
    // at position rr+j, take the lowest set bit, then rotate the offset back.
    // ------------------------------------------------------------------------
    assign w_req_rot = NUM_SRC'({s_axis_in_tvalid, s_axis_in_tvalid} >> r_rr);
    assign w_any_req = |w_req_rot;

    always_comb begin
        w_offset = 2'd0;
        for (int j = NUM_SRC - 1; j >= 0; j--) begin
            if (w_req_rot[j]) begin
                w_offset = 2'(j);
            end
        end
    end

    assign w_sum    = {1'b0, r_rr} + {1'b0, w_offset};
    assign w_winner = (w_sum >= c_NUM_SRC3) ? 2'(w_sum - c_NUM_SRC3) : w_sum[1:0];

    assign w_rr_next = (r_grant == c_LAST_SRC) ? 2'd0 : r_grant + 2'd1;

    // ------------------------------------------------------------------------
    // Ready is decoded from the registered state and grant only, so it is
    // one-hot by construction and independent of the input valids.
    // ------------------------------------------------------------------------
    always_comb begin
        w_ready    = '0;
        w_sel_data = '0;
        w_sel_last = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (r_grant == 2'(k)) begin
                w_ready[k] = (r_state == c_ST_GRANT);
                w_sel_data = s_axis_in_tdata[k*c_BEAT_W +: c_BEAT_W];
                w_sel_last = s_axis_in_tlast[k];
            end
        end
    end

    assign w_accept = |(s_axis_in_tvalid & w_ready);

`ifdef DEMAP_ARB_TIMEOUT_EN
    // ------------------------------------------------------------------------
    // Stall watchdog: counts consecutive GRANT cycles with no beat from the
    // locked source. The abort fires on the cycle that would make the count
    // reach TIMEOUT_CYC; err_o is registered so it appears on the next cycle,
    // together with the return to IDLE.
    // ------------------------------------------------------------------------
    localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

    logic [c_CNT_W-1:0] r_stall_cnt;
    logic               r_err;
    logic               w_timeout;

    assign w_timeout = (r_state == c_ST_GRANT) && !w_accept && (r_stall_cnt == c_CNT_LAST);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_stall_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if ((r_state != c_ST_GRANT) || w_accept || w_timeout) begin
                r_stall_cnt <= '0;
            end else begin
                r_stall_cnt <= r_stall_cnt + c_CNT_W'(1);
            end
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Arbitration FSM and registered output beat.
    // tlast is cleared on idle cycles so it can never be seen without tvalid.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state     <= c_ST_IDLE;
            r_grant     <= 2'd0;
            r_rr        <= 2'd0;
            r_out_data  <= '0;
            r_out_user  <= 2'd0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant <= w_winner;
                        r_state <= c_ST_GRANT;
                    end
                end
                c_ST_GRANT: begin
                    if (w_accept) begin
                        r_out_data  <= w_sel_data;
                        r_out_user  <= r_grant;
                        r_out_last  <= w_sel_last;
                        r_out_valid <= 1'b1;
                        if (w_sel_last) begin
                            r_state <= c_ST_IDLE;
                            r_rr    <= w_rr_next;
                        end
                    end
`ifdef DEMAP_ARB_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_state <= c_ST_IDLE;
                        r_rr    <= w_rr_next;
                    end
`endif
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign s_axis_in_tready  = w_ready;
    assign m_axis_out_tdata  = r_out_data;
    assign m_axis_out_tuser  = r_out_user;
    assign m_axis_out_tlast  = r_out_last;
    assign m_axis_out_tvalid = r_out_valid;
    assign grant_o           = r_grant;
    assign busy_o            = (r_state == c_ST_GRANT);

endmodule
`default_nettype wire
